// File: rtl/stream_mux_2_1.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_2_1
// Brief    : Two-input to one-output registered stream multiplexer with
//            valid/ready handshakes and a single output pipeline stage.
//            s reports which input the word in y came from.
//            Build option STREAM_MUX_RR_EN: when defined, contention is
//            resolved round-robin via a last-granted pointer; when undefined,
//            channel 0 has fixed priority and no pointer is built.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_2_1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] a1,
  input  logic             v1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             yv,
  input  logic             yr,
  output logic             s
);

  logic [WIDTH-1:0] r_y;
  logic             r_yv;
  logic             r_s;

  logic             w_ld;     // output register may take a new word
  logic             w_any;    // at least one channel is requesting
  logic             w_g;      // granted channel, meaningful only with w_any

  assign w_ld  = !r_yv || yr;
  assign w_any = v0 || v1;

`ifdef STREAM_MUX_RR_EN
  logic r_lp;

  // Last-granted pointer; resets to 1 so channel 0 wins the first contention
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lp <= 1'b1;
    end else if (w_ld && w_any) begin
      r_lp <= w_g;
    end
  end

  // Round-robin grant: a lone requester wins, contention goes to the other side
  always_comb begin
    w_g = 1'b0;
    if (v0 && v1) begin
      w_g = !r_lp;
    end else if (v1) begin
      w_g = 1'b1;
    end
  end
`else
  // Fixed-priority grant: channel 0 wins whenever it requests
  always_comb begin
    w_g = 1'b0;
    if (!v0 && v1) begin
      w_g = 1'b1;
    end
  end
`endif

  // Readies are forced low during reset so producers never see an acceptance
  assign r0 = rst_n && w_ld && v0 && !w_g;
  assign r1 = rst_n && w_ld && v1 &&  w_g;

  // Output stage: load the granted word, empty on no grant, hold on stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y  <= '0;
      r_yv <= 1'b0;
      r_s  <= 1'b0;
    end else if (w_ld) begin
      if (w_any) begin
        r_y  <= w_g ? a1 : a0;
        r_s  <= w_g;
        r_yv <= 1'b1;
      end else begin
        r_yv <= 1'b0;
      end
    end
  end

  assign y  = r_y;
  assign yv = r_yv;
  assign s  = r_s;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_2_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_2_1
// Brief    : Scoreboard bench for stream_mux_2_1. Directed stimulus pushes the
//            hand-computed expected output words; an independent monitor pops
//            and compares them on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_2_1;

  localparam int c_width = 8;

  typedef struct packed {
    logic [c_width-1:0] d;
    logic               s;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic [c_width-1:0] a0, a1;
  logic               v0, v1, yr;
  logic               r0, r1, yv, s;
  logic [c_width-1:0] y;

  exp_t q_exp[$];
  int   n_vec;
  int   n_bad;

  stream_mux_2_1 #(.WIDTH(c_width)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a0   (a0),
    .v0   (v0),
    .r0   (r0),
    .a1   (a1),
    .v1   (v1),
    .r1   (r1),
    .y    (y),
    .yv   (yv),
    .yr   (yr),
    .s    (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports failures
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [c_width-1:0] d, input logic sv);
    exp_t e;
    e.d = d;
    e.s = sv;
    q_exp.push_back(e);
  endtask

  // Monitor: every output transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && yv && yr) begin
      if (q_exp.size() == 0) begin
        check("unexpected_output", {24'd0, y}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("out_y", {24'd0, y}, {24'd0, e.d});
        check("out_s", {31'd0, s}, {31'd0, e.s});
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    a0 = 8'h11; a1 = 8'h22;
    yr = 1'b1;

    // Reset held two cycles with both valids high
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_y",  {24'd0, y},  32'h0);
      check("rst_yv", {31'd0, yv}, 32'h0);
      check("rst_s",  {31'd0, s},  32'h0);
      check("rst_r0", {31'd0, r0}, 32'h0);
      check("rst_r1", {31'd0, r1}, 32'h0);
    end
    step();
    rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    step();

    // Single channel 1 word
    v1 = 1'b1; a1 = 8'hA5; v0 = 1'b0; yr = 1'b1;
    push(8'hA5, 1'b1);
    @(negedge clk);
    check("single_r1", {31'd0, r1}, 32'h1);
    check("single_r0", {31'd0, r0}, 32'h0);
    step();
    v1 = 1'b0;
    @(negedge clk);
    check("single_yv", {31'd0, yv}, 32'h1);
    check("single_y",  {24'd0, y},  32'hA5);
    check("single_s",  {31'd0, s},  32'h1);
    step();
    step();

    // Contention for four cycles
    v0 = 1'b1; v1 = 1'b1; a0 = 8'h10; a1 = 8'h20; yr = 1'b1;
`ifdef STREAM_MUX_RR_EN
    push(8'h10, 1'b0); push(8'h20, 1'b1); push(8'h10, 1'b0); push(8'h20, 1'b1);
`else
    push(8'h10, 1'b0); push(8'h10, 1'b0); push(8'h10, 1'b0); push(8'h10, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef STREAM_MUX_RR_EN
      check("cont_r1", {31'd0, r1}, (i % 2 == 1) ? 32'h1 : 32'h0);
      check("cont_r0", {31'd0, r0}, (i % 2 == 0) ? 32'h1 : 32'h0);
`else
      check("cont_r1", {31'd0, r1}, 32'h0);
      check("cont_r0", {31'd0, r0}, 32'h1);
`endif
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    step();
    step();

    // Backpressure: load one word, stall three cycles, then release
    v0 = 1'b1; a0 = 8'h33; yr = 1'b1;
    push(8'h33, 1'b0);
    step();
    a0 = 8'h44; yr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_y",  {24'd0, y},  32'h33);
      check("bp_s",  {31'd0, s},  32'h0);
      check("bp_yv", {31'd0, yv}, 32'h1);
      check("bp_r0", {31'd0, r0}, 32'h0);
      step();
    end
    yr = 1'b1;
    push(8'h44, 1'b0);
    @(negedge clk);
    check("bp_release_r0", {31'd0, r0}, 32'h1);
    step();
    v0 = 1'b0;
    @(negedge clk);
    check("bp_nobubble_yv", {31'd0, yv}, 32'h1);
    check("bp_nobubble_y",  {24'd0, y},  32'h44);
    step();
    step();

    // Mid-stream reset discards the held word
    yr = 1'b0; v1 = 1'b1; a1 = 8'h20; v0 = 1'b0;
    step();
    v1 = 1'b0;
    @(negedge clk);
    check("mid_pre_y",  {24'd0, y},  32'h20);
    check("mid_pre_yv", {31'd0, yv}, 32'h1);
    step();
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; a0 = 8'h10; a1 = 8'h20; yr = 1'b1;
    @(negedge clk);
    check("mid_rst_r0", {31'd0, r0}, 32'h0);
    check("mid_rst_r1", {31'd0, r1}, 32'h0);
    step();
    rst_n = 1'b1;
    push(8'h10, 1'b0);
`ifdef STREAM_MUX_RR_EN
    push(8'h20, 1'b1);
`else
    push(8'h10, 1'b0);
`endif
    @(negedge clk);
    check("mid_post_yv", {31'd0, yv}, 32'h0);
    check("mid_post_y",  {24'd0, y},  32'h0);
    check("mid_post_r0", {31'd0, r0}, 32'h1);
    check("mid_post_r1", {31'd0, r1}, 32'h0);
    step();
    step();
    v0 = 1'b0; v1 = 1'b0;

    // Drain and confirm every expected word was observed
    for (int i = 0; i < 4; i++) step();
    check("scoreboard_empty", q_exp.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_mux_2_1.md
# stream_mux_2_1

Two-input to one-output registered stream multiplexer with valid/ready handshakes, round-robin arbitration and one output pipeline stage. It is the merging counterpart of the 1-to-2 demultiplexer: the demultiplexer steers one source to one of two destinations by `s`, and this block merges two sources onto one destination. The block drives `s` to report which input the current output word came from. It sits in front of any single-consumer datapath fed by two producers.

## Interface
Parameters:
- `WIDTH`, default 8: data width of every data port.

Ports:
- `clk`  input  1  rising-edge clock; the block's only clock.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `a0`  input  WIDTH  channel 0 data.
- `v0`  input  1  channel 0 valid.
- `r0`  output  1  channel 0 ready.
- `a1`  input  WIDTH  channel 1 data.
- `v1`  input  1  channel 1 valid.
- `r1`  output  1  channel 1 ready.
- `y`  output  WIDTH  output data (registered).
- `yv`  output  1  output valid (registered).
- `yr`  input  1  output ready from the downstream consumer.
- `s`  output  1  source channel of the word currently in `y` (registered).

## Operation
- Transfer rules:
  - An input transfer occurs on a cycle where `vN && rN`.
  - An output transfer occurs on a cycle where `yv && yr`.
- Load enable: `ld = !yv || yr`. The output register accepts a new word only when it is empty or is being emptied in the same cycle.
- Grant `g` is combinational. It is computed from `v0`, `v1` and the last-granted pointer `lp`:
  - Only `v0` high: `g = 0`.
  - Only `v1` high: `g = 1`.
  - Both high: `g = !lp` (round-robin).
  - Neither high: no grant.
- Ready outputs:
  - `r0 = ld && v0 && (g == 0)`.
  - `r1 = ld && v1 && (g == 1)`.
  - At most one ready is high in any cycle.
  - A ready never rises unless the matching valid is high.
- On a clock edge with `ld` and a grant:
  - `y <= a[g]`, `s <= g`, `yv <= 1`, `lp <= g`.
- On a clock edge with `ld` and no grant:
  - `yv <= 0`.
  - `y`, `s` and `lp` hold their values.
- On a clock edge without `ld` (`yv && !yr`):
  - `y`, `yv`, `s` and `lp` all hold (backpressure).
  - `r0 = r1 = 0`.
- Producers must hold `aN` and `vN` stable until their transfer completes. The block does not check this.
- State consists of the output register (`y`, `yv`, `s`) and `lp`. There is no other storage and no word is ever dropped or duplicated.

## Timing
- Reset values: `y = 0`, `yv = 0`, `s = 0`, `lp = 1`. Because `lp` resets to 1, channel 0 wins the first contention.
- Ready outputs during reset and in the first cycle after reset: `r0 = r1 = 0` while `rst_n` is low. In the first cycle after reset, readiness depends only on `v0`/`v1`.
- Latency: an input accepted at edge N appears on `y` with `yv = 1` after edge N.
- Throughput: with `yr` held high, one word per cycle.
  - With both inputs continuously valid, grants alternate 0,1,0,1… (round-robin build).
- Simultaneous output drain and refill: the output register reloads in the same cycle, with no bubble.
- Reset asserted mid-stream: the word held in `y` is discarded, `yv` goes low on that edge and `lp` returns to 1. Inputs must treat `rN = 0` during reset as "not accepted".
- Downstream stall: `yr = 0` while `yv = 1` freezes all state. Both readies stay low for as long as the stall lasts.

## Configuration
- `STREAM_MUX_RR_EN` defined: round-robin arbitration as described above, using the `lp` pointer.
- `STREAM_MUX_RR_EN` undefined: fixed priority.
  - When both inputs are valid, `g = 0`, so channel 0 always wins and channel 1 may starve.
  - The `lp` register is not built.
  - All other behaviour (handshake, latency, reset values) is identical.

## Test plan
- Reset: hold `rst_n = 0` for 2 cycles with `v0 = v1 = 1` -> `y = 0`, `yv = 0`, `s = 0`, `r0 = r1 = 0` throughout.
- Single channel: `v1 = 1`, `a1 = 8'hA5`, `v0 = 0`, `yr = 1` -> `r1 = 1` in that cycle; next cycle `y = 8'hA5`, `yv = 1`, `s = 1`.
- Contention, with `STREAM_MUX_RR_EN` defined: `v0 = v1 = 1` for 4 cycles, `a0 = 8'h10`, `a1 = 8'h20`, `yr = 1` -> `s` sequence is 0,1,0,1 and `y` sequence is 10,20,10,20.
- Contention, with the macro undefined, same stimulus -> `s` stays 0 for all 4 words and `r1` is never asserted.
- Backpressure: load one word, then `yr = 0` for 3 cycles with `v0 = 1` -> `y`, `s` and `yv = 1` are stable and `r0 = 0`; raising `yr` -> the next word loads on that same edge with no bubble cycle.
- Mid-stream reset: `yv = 1` and `y = 8'h20`, then pulse `rst_n = 0` for 1 cycle -> `yv = 0`, `y = 0`; the next contention grants channel 0 first.
